// File: rtl/dadda_div_pkg.sv
// rtl/dadda_div_pkg.sv - shared types and constants for the 16b/8b restoring divider
package dadda_div_pkg;

    localparam int DW_DEF = 8;
    localparam int DVD_W  = 2 * DW_DEF;
    localparam int CNT_W  = $clog2(DW_DEF);

    // Quotient reported for divide-by-zero and overflow
    localparam logic [DW_DEF-1:0] Q_SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dadda_div_16b_by_8b_div_step.sv
// rtl/dadda_div_16b_by_8b_div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   rem,
    input  logic          din,
    input  logic [DW-1:0] b,
    output logic [DW:0]   rem_next,
    output logic          q_bit
);

    logic [DW:0] shifted;
    logic [DW:0] trial;
    logic        borrow;

    assign shifted = {rem[DW-1:0], din};

    // Trial subtraction with an explicit borrow bit; borrow means "negative"
    assign {borrow, trial} = {1'b0, shifted} - {2'b00, b};

    // A set top bit of the partial remainder already guarantees the trial succeeds
    assign q_bit    = rem[DW] | ~borrow;
    assign rem_next = q_bit ? trial : shifted;

endmodule

// File: rtl/dadda_div_16b_by_8b.sv
// rtl/dadda_div_16b_by_8b.sv - sequential unsigned 16b/8b restoring divider (option: DIVIDER_TRUNC_EN)
module dadda_div_16b_by_8b
    import dadda_div_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int TRUNC_BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] A,
    input  logic [DW-1:0]   B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   Q,
    output logic [DW-1:0]   R,
    output logic            OVF,
    output logic            DZ
);

`ifdef DIVIDER_TRUNC_EN
    localparam int SKIP = TRUNC_BITS;
`else
    // The truncation depth has no effect in the exact build
    localparam int SKIP = 0 * TRUNC_BITS;
`endif

    localparam int ITERS = DW - SKIP;
    localparam int CW    = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t         state;
    logic [DW:0]    rem;
    logic [DW-1:0]  shreg;
    logic [DW-1:0]  b_reg;
    logic [CW-1:0]  cnt;

    logic [DW:0]    step_rem;
    logic           step_q;
    logic [DW-1:0]  q_shift;

    div_step #(.DW(DW)) u_step (
        .rem      (rem),
        .din      (shreg[DW-1]),
        .b        (b_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign q_shift = {Q[DW-2:0], step_q};

    // Control FSM and datapath registers: accept, iterate one quotient bit per cycle, hold result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= '0;
            R         <= '0;
            OVF       <= 1'b0;
            DZ        <= 1'b0;
            rem       <= '0;
            shreg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        b_reg <= B;
                        if (B == '0) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            DZ        <= 1'b1;
                            OVF       <= 1'b0;
                            Q         <= Q_SAT;
                            R         <= '0;
                        end else if (A[2*DW-1:DW] >= B) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            OVF       <= 1'b1;
                            DZ        <= 1'b0;
                            Q         <= Q_SAT;
                            R         <= '0;
                        end else begin
                            state    <= CALC;
                            in_ready <= 1'b0;
                            rem      <= {1'b0, A[2*DW-1:DW]};
                            shreg    <= A[DW-1:0];
                            cnt      <= '0;
                            Q        <= '0;
                            OVF      <= 1'b0;
                            DZ       <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    shreg <= {shreg[DW-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Q         <= q_shift << SKIP;
`ifdef DIVIDER_TRUNC_EN
                        R         <= '0;
`else
                        R         <= step_rem[DW-1:0];
`endif
                    end else begin
                        Q <= q_shift;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        OVF       <= 1'b0;
                        DZ        <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dadda_div_16b_by_8b.sv
// tb/tb_dadda_div_16b_by_8b.sv - self-checking bench for dadda_div_16b_by_8b
module tb_dadda_div_16b_by_8b;

    localparam int DW = 8;
    localparam int TB_TRUNC = 4;
`ifdef DIVIDER_TRUNC_EN
    localparam int SKIP = TB_TRUNC;
`else
    localparam int SKIP = 0;
`endif
    localparam int NORM_LAT = DW - SKIP + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = '0;
    logic [7:0]  b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  q_out;
    logic [7:0]  r_out;
    logic        ovf_out;
    logic        dz_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dadda_div_16b_by_8b #(.DW(DW), .TRUNC_BITS(TB_TRUNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (q_out),
        .R         (r_out),
        .OVF       (ovf_out),
        .DZ        (dz_out)
    );

    // Reference: plain integer division with the error rules and truncation applied
    task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic ovf, output logic dz, output int lat);
        int unsigned qi;
        q = 8'hFF; r = 8'h00; ovf = 1'b0; dz = 1'b0; lat = 1;
        if (b == 0) begin
            dz = 1'b1;
        end else begin
            qi = a / b;
            if (qi > 255) begin
                ovf = 1'b1;
            end else begin
                q   = 8'(qi) & ~8'((1 << SKIP) - 1);
                r   = (SKIP == 0) ? 8'(a % b) : 8'h00;
                lat = NORM_LAT;
            end
        end
    endtask

    // Drives one operand pair, waits for the result, returns what the DUT produced, then drains it
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic ovf, output logic dz, output int lat);
        int n;
        @(negedge clk);
        a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        q = q_out; r = r_out; ovf = ovf_out; dz = dz_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_out !== 8'h00 || r_out !== 8'h00 ||
            ovf_out !== 1'b0 || dz_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b Q=%h R=%h OVF=%b DZ=%b, want rdy=1 vld=0 Q=00 R=00 OVF=0 DZ=0",
                     in_ready, out_valid, q_out, r_out, ovf_out, dz_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] av [4] = '{16'd1000, 16'hFE01, 16'h1234, 16'h0800};
        logic [7:0]  bv [4] = '{8'd7, 8'hFF, 8'h00, 8'd8};
        logic [7:0] q, r, eq, er;
        logic ovf, dz, eovf, edz;
        int lat, elat;
        for (int i = 0; i < 4; i++) begin
            run_div(av[i], bv[i], q, r, ovf, dz, lat);
            ref_div(av[i], bv[i], eq, er, eovf, edz, elat);
            checks++;
            if (q !== eq || r !== er || ovf !== eovf || dz !== edz || lat != elat) begin
                failures++;
                $display("FAIL directed_%0d: A=%h B=%h got Q=%h R=%h OVF=%b DZ=%b lat=%0d, want Q=%h R=%h OVF=%b DZ=%b lat=%0d",
                         i, av[i], bv[i], q, r, ovf, dz, lat, eq, er, eovf, edz, elat);
            end
        end
        // Independent constants for the headline cases
        run_div(16'd1000, 8'd7, q, r, ovf, dz, lat);
        checks++;
        if (q !== ((SKIP == 0) ? 8'd142 : 8'h80) || r !== ((SKIP == 0) ? 8'd6 : 8'd0) || lat != NORM_LAT) begin
            failures++;
            $display("FAIL const_1000_7: got Q=%0d R=%0d lat=%0d, want Q=%0d R=%0d lat=%0d",
                     q, r, lat, (SKIP == 0) ? 142 : 128, (SKIP == 0) ? 6 : 0, NORM_LAT);
        end
    endtask

    task automatic test_dadda_sweep();
        logic [7:0] q, r, eq, er;
        logic ovf, dz, eovf, edz;
        logic [7:0]  x, y;
        logic [15:0] p;
        int lat, elat;
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom_range(1, 255));
            y = 8'($urandom_range(0, 255));
            p = 16'(x * y);
            run_div(p, x, q, r, ovf, dz, lat);
            ref_div(p, x, eq, er, eovf, edz, elat);
            checks++;
            if (q !== (y & ~8'((1 << SKIP) - 1)) || r !== 8'h00 || ovf !== 1'b0 || dz !== 1'b0 || q !== eq) begin
                failures++;
                $display("FAIL dadda_inverse: P=%h A=%h got Q=%h R=%h OVF=%b DZ=%b, want Q=%h R=00",
                         p, x, q, r, ovf, dz, eq);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] q, r, eq, er;
        logic ovf, dz, eovf, edz;
        logic [15:0] a;
        logic [7:0]  b;
        int lat, elat;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            b = (i % 10 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if (i % 3 == 0) a[15:8] = 8'($urandom) % ((b == 0) ? 8'd1 : b);
            run_div(a, b, q, r, ovf, dz, lat);
            ref_div(a, b, eq, er, eovf, edz, elat);
            checks++;
            if (q !== eq || r !== er || ovf !== eovf || dz !== edz || lat != elat) begin
                failures++;
                $display("FAIL random: A=%h B=%h got Q=%h R=%h OVF=%b DZ=%b lat=%0d, want Q=%h R=%h OVF=%b DZ=%b lat=%0d",
                         a, b, q, r, ovf, dz, lat, eq, er, eovf, edz, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q0, r0, eq, er;
        logic eovf, edz;
        int n, elat;
        @(negedge clk);
        a_in = 16'd1000; b_in = 8'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Keep a new request pending while the result is held
        a_in = 16'd2000; b_in = 8'd9;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL bp_timeout: out_valid=%b, want 1", out_valid);
        end
        q0 = q_out; r0 = r_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_out !== q0 || r_out !== r0) begin
                failures++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b Q=%h R=%h, want vld=1 rdy=0 Q=%h R=%h",
                         i, out_valid, in_ready, q_out, r_out, q0, r0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept_next: rdy=%b, want 0", in_ready);
        end
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        ref_div(16'd2000, 8'd9, eq, er, eovf, edz, elat);
        checks++;
        if (out_valid !== 1'b1 || q_out !== eq || r_out !== er) begin
            failures++;
            $display("FAIL bp_second: vld=%b Q=%h R=%h, want vld=1 Q=%h R=%h", out_valid, q_out, r_out, eq, er);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic [7:0] q, r;
        logic ovf, dz;
        int lat;
        @(negedge clk);
        a_in = 16'd1000; b_in = 8'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_out !== 8'h00 || r_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_calc: rdy=%b vld=%b Q=%h R=%h, want rdy=1 vld=0 Q=00 R=00",
                     in_ready, out_valid, q_out, r_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_div(16'd1000, 8'd7, q, r, ovf, dz, lat);
        checks++;
        if (q !== ((SKIP == 0) ? 8'd142 : 8'h80) || r !== ((SKIP == 0) ? 8'd6 : 8'd0) || ovf !== 1'b0 || dz !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_div: Q=%0d R=%0d OVF=%b DZ=%b, want Q=%0d R=%0d",
                     q, r, ovf, dz, (SKIP == 0) ? 142 : 128, (SKIP == 0) ? 6 : 0);
        end
    endtask

    task automatic test_back_to_back();
        int rise [$];
        logic prev;
        @(negedge clk);
        a_in = 16'd5000; b_in = 8'd77; in_valid = 1'b1; out_ready = 1'b1;
        prev = out_valid;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (out_valid && !prev) rise.push_back(c);
            prev = out_valid;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (rise.size() < 3 || (rise[2] - rise[1]) != (DW - SKIP + 2)) begin
            failures++;
            $display("FAIL back_to_back_period: results=%0d period=%0d, want >=3 results period=%0d",
                     rise.size(), (rise.size() >= 3) ? rise[2] - rise[1] : -1, DW - SKIP + 2);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_dadda_sweep();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
